// File: rtl/dmem_arb_pkg.sv
// Shared types and default addresses for the data-memory port arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CPU_WAIT,
    KB_WAIT,
    DISP_WAIT
  } arb_state_e;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_CPU,
    GNT_KB,
    GNT_DISP
  } gnt_src_e;

  localparam logic [31:0] DEF_KB_ADDR    = 32'd10;
  localparam logic [31:0] DEF_MONEY_ADDR = 32'd20;

endpackage

// File: rtl/kb_code_fifo.sv
// Small synchronous FIFO buffering PS/2 key codes until the memory port is free.
module kb_code_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rstin,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rstin) begin
    if (!rstin) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single data-memory port between CPU, buffered key-code writes
// and the periodic money-word read for the display.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter logic [31:0] KB_ADDR        = DEF_KB_ADDR,
  parameter logic [31:0] MONEY_ADDR     = DEF_MONEY_ADDR,
  parameter int          KB_DEPTH       = 4,
  parameter int          REFRESH_PERIOD = 1024,
  parameter int          STARVE_LIMIT   = 16
) (
  input  logic        clk,
  input  logic        rstin,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ack,
  output logic [31:0] cpu_rdata,
  input  logic        kb_valid,
  input  logic [7:0]  kb_code,
  output logic        kb_overflow,
  output logic [9:0]  money,
  output logic        money_valid,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int RW = $clog2(REFRESH_PERIOD);

  arb_state_e    state;
  arb_state_e    state_nxt;
  gnt_src_e      gnt;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_head;
  logic          kb_pop;
  logic [SW-1:0] starve_cnt;
  logic          starved;
  logic [RW-1:0] refresh_cnt;
  logic          refresh_wrap;
  logic          refresh_pending;
  logic          cpu_we_q;
  logic [31:0]   rdata_q;

  kb_code_fifo #(
    .DEPTH(KB_DEPTH)
  ) u_kb_fifo (
    .clk  (clk),
    .rstin(rstin),
    .push (kb_valid),
    .din  (kb_code),
    .pop  (kb_pop),
    .dout (fifo_head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign starved      = (starve_cnt == SW'(STARVE_LIMIT));
  assign refresh_wrap = (refresh_cnt == RW'(REFRESH_PERIOD - 1));
  assign kb_pop       = (gnt == GNT_KB);

  always_comb begin
    gnt = GNT_NONE;
    if (state == IDLE) begin
      if (starved && !fifo_empty) gnt = GNT_KB;
      else if (cpu_req)           gnt = GNT_CPU;
      else if (!fifo_empty)       gnt = GNT_KB;
      else if (refresh_pending)   gnt = GNT_DISP;
    end
  end

  // Every op is one issue cycle in IDLE followed by exactly one wait cycle.
  always_comb begin
    state_nxt = IDLE;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (gnt)
      GNT_CPU: begin
        state_nxt = CPU_WAIT;
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end
      GNT_KB: begin
        state_nxt = KB_WAIT;
        mem_we    = 1'b1;
        mem_addr  = KB_ADDR;
        mem_wdata = {24'd0, fifo_head};
      end
      GNT_DISP: begin
        state_nxt = DISP_WAIT;
        mem_addr  = MONEY_ADDR;
      end
      default: ;
    endcase
    // Keep the memory bus quiet while reset is held, even if the CPU is requesting.
    if (!rstin) begin
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
    end
  end

  always_ff @(posedge clk or negedge rstin) begin
    if (!rstin) begin
      state           <= IDLE;
      cpu_ack         <= 1'b0;
      cpu_we_q        <= 1'b0;
      rdata_q         <= '0;
      money           <= '0;
      money_valid     <= 1'b0;
      kb_overflow     <= 1'b0;
      starve_cnt      <= '0;
      refresh_cnt     <= '0;
      refresh_pending <= 1'b0;
    end else begin
      state   <= state_nxt;
      cpu_ack <= (gnt == GNT_CPU);
      if (gnt == GNT_CPU) cpu_we_q <= cpu_we;
      if (state == CPU_WAIT && !cpu_we_q) rdata_q <= mem_rdata;
      if (state == DISP_WAIT) begin
        money       <= mem_rdata[9:0];
        money_valid <= 1'b1;
      end
      if (kb_valid && fifo_full && !kb_pop) kb_overflow <= 1'b1;
      if (kb_pop || fifo_empty)        starve_cnt <= '0;
      else if (!starved)               starve_cnt <= starve_cnt + 1'b1;
      refresh_cnt <= refresh_wrap ? '0 : refresh_cnt + 1'b1;
      // A wrap landing on the completing read re-arms the request.
      if (refresh_wrap)             refresh_pending <= 1'b1;
      else if (state == DISP_WAIT)  refresh_pending <= 1'b0;
    end
  end

  // Load data is forwarded straight from memory in the ack cycle and held afterwards.
  assign cpu_rdata = (state == CPU_WAIT && !cpu_we_q) ? mem_rdata : rdata_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Randomised bench for dmem_port_arbiter with a queue-based reference model.
module tb_dmem_port_arbiter;

  localparam logic [31:0] KB_ADDR        = 32'd10;
  localparam logic [31:0] MONEY_ADDR     = 32'd20;
  localparam int          KB_DEPTH       = 4;
  localparam int          REFRESH_PERIOD = 1024;
  localparam int          STARVE_LIMIT   = 16;

  logic        clk = 1'b0;
  logic        rstin;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_ack;
  logic [31:0] cpu_rdata;
  logic        kb_valid;
  logic [7:0]  kb_code;
  logic        kb_overflow;
  logic [9:0]  money;
  logic        money_valid;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_clr;

  always #5 clk = ~clk;

  dmem_port_arbiter #(
    .KB_ADDR       (KB_ADDR),
    .MONEY_ADDR    (MONEY_ADDR),
    .KB_DEPTH      (KB_DEPTH),
    .REFRESH_PERIOD(REFRESH_PERIOD),
    .STARVE_LIMIT  (STARVE_LIMIT)
  ) dut (
    .clk        (clk),
    .rstin      (rstin),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ack    (cpu_ack),
    .cpu_rdata  (cpu_rdata),
    .kb_valid   (kb_valid),
    .kb_code    (kb_code),
    .kb_overflow(kb_overflow),
    .money      (money),
    .money_valid(money_valid),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Single-port synchronous memory, one-cycle read latency
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (mem_we) begin
      mem[mem_addr[7:0]] <= mem_wdata;
    end
    mem_rdata <= mem[mem_addr[7:0]];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: who owns the memory this cycle, what it will return, key queue
  logic [31:0] ref_mem [256];
  logic [7:0]  kq [$];
  string       inflight;
  logic [31:0] inflight_data;
  bit          inflight_load;
  int          starve;
  int          rtimer;
  bit          rpend;
  logic [9:0]  m_money;
  bit          m_mvalid;
  bit          m_ovf;

  task automatic model_reset();
    kq.delete();
    inflight      = "";
    inflight_data = '0;
    inflight_load = 1'b0;
    starve        = 0;
    rtimer        = 0;
    rpend         = 1'b0;
    m_money       = '0;
    m_mvalid      = 1'b0;
    m_ovf         = 1'b0;
  endtask

  task automatic model_step();
    string       g;
    bit          ewe;
    logic [31:0] ea;
    logic [31:0] ewd;
    g = ""; ewe = 1'b0; ea = '0; ewd = '0;
    chk("cpu_ack", {31'd0, cpu_ack}, {31'd0, inflight == "cpu"});
    if (inflight == "cpu" && inflight_load) chk("cpu_rdata", cpu_rdata, inflight_data);
    chk("money", {22'd0, money}, {22'd0, m_money});
    chk("money_valid", {31'd0, money_valid}, {31'd0, m_mvalid});
    chk("kb_overflow", {31'd0, kb_overflow}, {31'd0, m_ovf});
    if (inflight == "") begin
      if (kq.size() > 0 && starve >= STARVE_LIMIT) g = "kb";
      else if (cpu_req)                            g = "cpu";
      else if (kq.size() > 0)                      g = "kb";
      else if (rpend)                              g = "disp";
    end
    if (g == "cpu") begin
      ewe = cpu_we; ea = cpu_addr; ewd = cpu_wdata;
    end else if (g == "kb") begin
      ewe = 1'b1; ea = KB_ADDR; ewd = {24'd0, kq[0]};
    end else if (g == "disp") begin
      ea = MONEY_ADDR;
    end
    chk("mem_we", {31'd0, mem_we}, {31'd0, ewe});
    if (g != "") chk("mem_addr", mem_addr, ea);
    if (ewe) chk("mem_wdata", mem_wdata, ewd);

    if (inflight == "disp") begin
      m_money  = inflight_data[9:0];
      m_mvalid = 1'b1;
      rpend    = 1'b0;
    end
    rtimer++;
    if (rtimer == REFRESH_PERIOD) begin
      rtimer = 0;
      rpend  = 1'b1;
    end
    if (g == "kb" || kq.size() == 0) starve = 0;
    else if (starve < STARVE_LIMIT)  starve++;
    inflight      = g;
    inflight_load = 1'b0;
    if (g == "cpu") begin
      inflight_load = !cpu_we;
      inflight_data = ref_mem[cpu_addr[7:0]];
      if (cpu_we) ref_mem[cpu_addr[7:0]] = cpu_wdata;
    end else if (g == "kb") begin
      ref_mem[KB_ADDR[7:0]] = {24'd0, kq[0]};
      void'(kq.pop_front());
    end else if (g == "disp") begin
      inflight_data = ref_mem[MONEY_ADDR[7:0]];
    end
    if (kb_valid) begin
      if (kq.size() < KB_DEPTH) kq.push_back(kb_code);
      else                      m_ovf = 1'b1;
    end
  endtask

  int          cyc;
  bit          ack_seen;
  bit          obs_we;
  bit          obs_kbw;
  logic [31:0] obs_wdata;
  logic [31:0] got_rdata;

  task automatic tick();
    @(negedge clk);
    ack_seen  = cpu_ack;
    obs_we    = mem_we;
    obs_kbw   = mem_we && (mem_addr == KB_ADDR);
    obs_wdata = mem_wdata;
    if (cpu_ack) got_rdata = cpu_rdata;
    model_step();
    @(posedge clk); #1;
    kb_valid = 1'b0;
    if (ack_seen) cpu_req = 1'b0;
    cyc++;
  endtask

  task automatic cpu_op(input bit we, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output bit first_we);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    lat = 0; first_we = 1'b0;
    do begin
      tick();
      lat++;
      if (lat == 1) first_we = obs_we;
    end while (!ack_seen && lat < 20);
    chk("cpu_ack_seen", {31'd0, ack_seen}, 32'd1);
  endtask

  task automatic finish_cpu();
    for (int i = 0; i < 10 && cpu_req; i++) tick();
  endtask

  initial begin
    int lat;
    bit fw;
    int kb_tick;
    int acks_after;

    rstin = 1'b0; mem_clr = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    kb_valid = 1'b0; kb_code = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    model_reset();
    cyc = 0; ack_seen = 1'b0; got_rdata = '0;
    repeat (2) @(posedge clk);
    #1 mem_clr = 1'b0;
    @(negedge clk);
    chk("rst_cpu_ack", {31'd0, cpu_ack}, 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk("rst_kb_overflow", {31'd0, kb_overflow}, 32'd0);
    chk("rst_money", {22'd0, money}, 32'd0);
    chk("rst_money_valid", {31'd0, money_valid}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    @(posedge clk); #1;
    rstin = 1'b1;
    model_reset();
    cyc = 0;

    // Money word for the first display refresh, upper bits must be ignored
    cpu_op(1'b1, MONEY_ADDR, 32'hABCD_F2A5, lat, fw);

    cpu_op(1'b1, 32'h40, 32'hDEAD_BEEF, lat, fw);
    chk("store_issue_we", {31'd0, fw}, 32'd1);
    chk("store_latency", lat, 32'd2);
    cpu_op(1'b0, 32'h40, 32'h0, lat, fw);
    chk("load_issue_we", {31'd0, fw}, 32'd0);
    chk("load_latency", lat, 32'd2);
    chk("load_data", got_rdata, 32'hDEAD_BEEF);

    kb_valid = 1'b1; kb_code = 8'h1C;
    tick();
    tick();
    chk("kb_write_we", {31'd0, obs_kbw}, 32'd1);
    chk("kb_write_data", obs_wdata, 32'h0000_001C);
    tick();
    tick();
    chk("kb_fifo_drained", {31'd0, obs_we}, 32'd0);

    // CPU saturates the port; one key must still get through via the starvation guard
    cpu_we = 1'b0; cpu_addr = 32'h40; cpu_wdata = '0;
    kb_tick = -1; acks_after = 0;
    for (int i = 0; i < 60; i++) begin
      if (!cpu_req) cpu_req = 1'b1;
      if (i == 3) begin kb_valid = 1'b1; kb_code = 8'h23; end
      tick();
      if (obs_kbw && kb_tick < 0) kb_tick = i;
      else if (kb_tick >= 0 && ack_seen) acks_after++;
    end
    finish_cpu();
    chk("starve_grant_delay", {31'd0, (kb_tick - 3 == 17) || (kb_tick - 3 == 18)}, 32'd1);
    chk("starve_mem10", mem[KB_ADDR[7:0]], 32'h0000_0023);
    chk("cpu_after_kb", {31'd0, acks_after > 0}, 32'd1);

    for (int i = 0; i < 100; i++) begin
      if (!cpu_req) cpu_req = 1'b1;
      if (i < 5) begin kb_valid = 1'b1; kb_code = 8'(8'h30 + i); end
      tick();
      if (i == 6) chk("ovf_set", {31'd0, kb_overflow}, 32'd1);
    end
    finish_cpu();
    chk("ovf_sticky", {31'd0, kb_overflow}, 32'd1);
    chk("ovf_last_code", mem[KB_ADDR[7:0]], 32'h0000_0033);

    while (cyc < REFRESH_PERIOD + 6) begin
      if (cyc == REFRESH_PERIOD - 4) chk("money_valid_early", {31'd0, money_valid}, 32'd0);
      tick();
    end
    chk("money_value", {22'd0, money}, 32'h2A5);
    chk("money_valid_set", {31'd0, money_valid}, 32'd1);

    // Reset while the CPU load is in its wait cycle
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40; cpu_wdata = '0;
    tick();
    rstin = 1'b0;
    #1;
    chk("midrst_cpu_ack", {31'd0, cpu_ack}, 32'd0);
    chk("midrst_cpu_rdata", cpu_rdata, 32'd0);
    chk("midrst_kb_overflow", {31'd0, kb_overflow}, 32'd0);
    chk("midrst_money", {22'd0, money}, 32'd0);
    chk("midrst_money_valid", {31'd0, money_valid}, 32'd0);
    chk("midrst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("midrst_mem_addr", mem_addr, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_hold_ack", {31'd0, cpu_ack}, 32'd0);
    rstin = 1'b1;
    model_reset();
    cyc = 0;
    lat = 0;
    do begin tick(); lat++; end while (!ack_seen && lat < 20);
    chk("postrst_ack_seen", {31'd0, ack_seen}, 32'd1);
    chk("postrst_latency", lat, 32'd2);
    chk("postrst_data", got_rdata, 32'hDEAD_BEEF);

    for (int i = 0; i < 3000; i++) begin
      if (!cpu_req && $urandom_range(0, 2) == 0) begin
        cpu_req   = 1'b1;
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = 32'($urandom_range(0, 63));
        cpu_wdata = $urandom;
      end
      if ($urandom_range(0, 5) == 0) begin
        kb_valid = 1'b1;
        kb_code  = 8'($urandom);
      end
      tick();
    end
    finish_cpu();
    repeat (4) tick();
    for (int i = 0; i < 64; i++) chk($sformatf("mem[%0d]", i), mem[i], ref_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
